// File: rtl/safe_controller.sv
// Keypad-driven digital safe: 4x3 keypad decode/debounce, 1-6 digit code entry,
// password compare with three-strike lockout, and in-place password change.
module safe_controller #(
  parameter int unsigned DEBOUNCE = 100000
) (
  input  logic       clk,
  input  logic       initialize,
  input  logic       row1,
  input  logic       row2,
  input  logic       row3,
  input  logic       row4,
  input  logic       col1,
  input  logic       col2,
  input  logic       col3,
  input  logic       reset,
  output logic [5:0] password_led,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_ON     = 3'd1,
    S_WRONG1 = 3'd2,
    S_WRONG2 = 3'd3,
    S_OPEN   = 3'd4,
    S_RESET  = 3'd5,
    S_LOCK   = 3'd6
  } state_t;

  localparam logic [3:0] K_STAR = 4'd10;
  localparam logic [3:0] K_HASH = 4'd11;
  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
  localparam logic [5:0][3:0] PW_INIT = {4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1};

  // ---------------- keypad synchronizer ----------------
  logic [6:0] key_s1, key_s2;
  logic [3:0] rows_s;
  logic [2:0] cols_s;

  assign rows_s = key_s2[6:3];
  assign cols_s = key_s2[2:0];

  // Decoded key: bit 4 = valid, bits 3:0 = code (0-9, star, hash)
  logic [4:0] dec;

  always_comb begin
    dec = '0;
    if ($onehot(rows_s) && $onehot(cols_s)) begin
      dec[4] = 1'b1;
      unique case (1'b1)
        rows_s[0]: dec[3:0] = cols_s[0] ? 4'd1 : (cols_s[1] ? 4'd2 : 4'd3);
        rows_s[1]: dec[3:0] = cols_s[0] ? 4'd4 : (cols_s[1] ? 4'd5 : 4'd6);
        rows_s[2]: dec[3:0] = cols_s[0] ? 4'd7 : (cols_s[1] ? 4'd8 : 4'd9);
        rows_s[3]: dec[3:0] = cols_s[0] ? K_STAR : (cols_s[1] ? 4'd0 : K_HASH);
        default:   dec[3:0] = '0;
      endcase
    end
  end

  // ---------------- debounce ----------------
  logic [4:0]    cand;
  logic [CW-1:0] cnt;
  logic [4:0]    deb;
  logic          deb_valid_q;

  always_ff @(posedge clk or negedge initialize) begin
    if (!initialize) begin
      key_s1      <= '0;
      key_s2      <= '0;
      cand        <= '0;
      cnt         <= '0;
      deb         <= '0;
      deb_valid_q <= 1'b0;
    end else begin
      key_s1      <= {row4, row3, row2, row1, col3, col2, col1};
      key_s2      <= key_s1;
      deb_valid_q <= deb[4];
      if (dec != cand) begin
        cand <= dec;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end else begin
        deb <= cand;
      end
    end
  end

  // A press counts only on a debounced no-key -> key transition
  logic       accept;
  logic [3:0] key_code;
  logic       is_digit;

  assign accept   = deb[4] & ~deb_valid_q;
  assign key_code = deb[3:0];
  assign is_digit = (key_code <= 4'd9);

  // ---------------- reset-button synchronizer ----------------
  logic rs_s1, rs_s2, rs_s3;
  logic rst_evt;

  always_ff @(posedge clk or negedge initialize) begin
    if (!initialize) begin
      rs_s1 <= 1'b0;
      rs_s2 <= 1'b0;
      rs_s3 <= 1'b0;
    end else begin
      rs_s1 <= reset;
      rs_s2 <= rs_s1;
      rs_s3 <= rs_s2;
    end
  end

  assign rst_evt = rs_s2 & ~rs_s3;

  // ---------------- controller FSM ----------------
  state_t          state_q, state_n;
  logic [5:0][3:0] buf_q, buf_n;
  logic [2:0]      ent_q, ent_n;
  logic [5:0][3:0] pw_q, pw_n;
  logic [2:0]      pwlen_q, pwlen_n;
  logic [5:0]      led_q, led_n;
  logic            match;

  always_ff @(posedge clk or negedge initialize) begin
    if (!initialize) begin
      state_q <= S_OFF;
      buf_q   <= '0;
      ent_q   <= '0;
      pw_q    <= PW_INIT;
      pwlen_q <= 3'd4;
      led_q   <= '0;
    end else begin
      state_q <= state_n;
      buf_q   <= buf_n;
      ent_q   <= ent_n;
      pw_q    <= pw_n;
      pwlen_q <= pwlen_n;
      led_q   <= led_n;
    end
  end

  always_comb begin
    match = (ent_q == pwlen_q);
    for (int unsigned i = 0; i < 6; i++) begin
      if ((3'(i) < ent_q) && (buf_q[i] != pw_q[i])) match = 1'b0;
    end
  end

  always_comb begin
    state_n = state_q;
    buf_n   = buf_q;
    ent_n   = ent_q;
    pw_n    = pw_q;
    pwlen_n = pwlen_q;
    led_n   = '0;

    unique case (state_q)
      S_OFF: begin
        if (accept) state_n = S_ON;
      end
      S_ON, S_WRONG1, S_WRONG2: begin
        if (accept) begin
          if (is_digit) begin
            if (ent_q < 3'd6) begin
              buf_n[ent_q] = key_code;
              ent_n        = ent_q + 3'd1;
            end
          end else if (key_code == K_STAR) begin
            ent_n = '0;
          end else if (key_code == K_HASH) begin
            if (match)                  state_n = S_OPEN;
            else if (state_q == S_ON)   state_n = S_WRONG1;
            else if (state_q == S_WRONG1) state_n = S_WRONG2;
            else                        state_n = S_LOCK;
          end
        end
      end
      S_OPEN: begin
        // Reset edge takes priority over a key accepted in the same cycle
        if (rst_evt)                             state_n = S_RESET;
        else if (accept && key_code == K_STAR)   state_n = S_ON;
      end
      S_RESET: begin
        if (accept) begin
          if (is_digit) begin
            if (ent_q < 3'd6) begin
              buf_n[ent_q] = key_code;
              ent_n        = ent_q + 3'd1;
            end
          end else if (key_code == K_STAR) begin
            ent_n = '0;
          end else if (key_code == K_HASH && ent_q != 3'd0) begin
            pw_n    = buf_q;
            pwlen_n = ent_q;
            state_n = S_ON;
          end
        end
      end
      S_LOCK: begin
        state_n = S_LOCK;
      end
      default: begin
        state_n = S_OFF;
      end
    endcase

    if (state_n != state_q) ent_n = '0;

    for (int unsigned i = 0; i < 6; i++) begin
      led_n[5 - i] = (3'(i) < ent_n);
    end
  end

  assign state        = state_q;
  assign password_led = led_q;

endmodule

// File: tb/tb_safe_controller.sv
// Scoreboard bench for safe_controller: each keypad press or reset pulse pushes
// its expected (state, password_led), which is popped and compared once settled.
module tb_safe_controller;

  logic       clk = 1'b0;
  logic       initialize = 1'b0;
  logic       row1 = 1'b0, row2 = 1'b0, row3 = 1'b0, row4 = 1'b0;
  logic       col1 = 1'b0, col2 = 1'b0, col3 = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] password_led;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    int    st;
    int    led;
  } exp_t;

  exp_t sb[$];

  safe_controller #(.DEBOUNCE(4)) dut (
    .clk          (clk),
    .initialize   (initialize),
    .row1         (row1),
    .row2         (row2),
    .row3         (row3),
    .row4         (row4),
    .col1         (col1),
    .col2         (col2),
    .col3         (col3),
    .reset        (reset),
    .password_led (password_led),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    if (obs !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int therm(input int n);
    int v;
    v = 0;
    for (int i = 0; i < n && i < 6; i++) v |= (32 >> i);
    return v;
  endfunction

  task automatic set_pins(input logic [3:0] r, input logic [2:0] c);
    {row4, row3, row2, row1} = r;
    {col3, col2, col1}       = c;
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "/state"}, 32'(state), e.st);
      check({e.tag, "/led"}, 32'(password_led), e.led);
    end
  endtask

  task automatic press_pins(input logic [3:0] r, input logic [2:0] c, input int hold,
                            input string tag, input int st, input int led);
    sb.push_back('{tag, st, led});
    @(negedge clk);
    set_pins(r, c);
    repeat (hold) @(negedge clk);
    set_pins('0, '0);
    repeat (12) @(negedge clk);
    compare_front();
  endtask

  // Key numbering: 0-9 digits, 10 = star, 11 = hash
  task automatic key_pins(input int k, output logic [3:0] r, output logic [2:0] c);
    if (k >= 1 && k <= 9) begin
      r = 4'(1 << ((k - 1) / 3));
      c = 3'(1 << ((k - 1) % 3));
    end else if (k == 0) begin
      r = 4'b1000; c = 3'b010;
    end else if (k == 10) begin
      r = 4'b1000; c = 3'b001;
    end else begin
      r = 4'b1000; c = 3'b100;
    end
  endtask

  task automatic press(input int k, input string tag, input int st, input int led);
    logic [3:0] r;
    logic [2:0] c;
    key_pins(k, r, c);
    press_pins(r, c, 12, tag, st, led);
  endtask

  task automatic pulse_reset(input string tag, input int st, input int led);
    sb.push_back('{tag, st, led});
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    compare_front();
  endtask

  task automatic pulse_init();
    @(negedge clk);
    initialize = 1'b0;
    repeat (2) @(negedge clk);
    initialize = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat;

    // Power-on
    repeat (3) @(negedge clk);
    check("rst_low/state", 32'(state), 0);
    check("rst_low/led", 32'(password_led), 0);
    initialize = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rel/state", 32'(state), 0);
    check("rst_rel/led", 32'(password_led), 0);

    // First press (key 5) with latency bound, OFF -> ON, key not entered
    sb.push_back('{"power_on_5", 1, 0});
    @(negedge clk);
    set_pins(4'b0010, 3'b010);
    lat = 0;
    while (state == 3'd0 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("key_latency_le_8", 32'(lat >= 1 && lat <= 8), 1);
    repeat (8) @(negedge clk);
    set_pins('0, '0);
    repeat (12) @(negedge clk);
    compare_front();

    // Correct entry
    press(1, "ok_1", 1, therm(1));
    press(2, "ok_2", 1, therm(2));
    press(3, "ok_3", 1, 6'b111000);
    press(4, "ok_4", 1, 6'b111100);
    press(11, "ok_hash", 4, 0);
    press(10, "open_star", 1, 0);

    // Lockout
    for (int t = 0; t < 3; t++) begin
      press(9, "lk_9a", 1 + t, therm(1));
      press(9, "lk_9b", 1 + t, therm(2));
      press(11, "lk_hash", (t == 2) ? 6 : 2 + t, 0);
    end
    press(1, "lock_1", 6, 0);
    press(2, "lock_2", 6, 0);
    press(3, "lock_3", 6, 0);
    press(4, "lock_4", 6, 0);
    press(11, "lock_hash", 6, 0);
    pulse_reset("lock_reset", 6, 0);
    pulse_init();
    check("lock_init/state", 32'(state), 0);

    // Password change
    press(5, "pc_wake", 1, 0);
    for (int i = 1; i <= 4; i++) press(i, "pc_old", 1, therm(i));
    press(11, "pc_open", 4, 0);
    sb.push_back('{"pc_reset_lat", 5, 0});
    @(negedge clk);
    reset = 1'b1;
    lat = 0;
    while (state != 3'd5 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("reset_latency_le_4", 32'(lat >= 1 && lat <= 4), 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    compare_front();
    press(11, "pc_empty_hash", 5, 0);
    for (int i = 1; i <= 7; i++) press(7, "pc_7", 5, therm(i));
    press(11, "pc_store", 1, 0);
    for (int i = 1; i <= 4; i++) press(i, "pc_1234", 1, therm(i));
    press(11, "pc_old_wrong", 2, 0);
    for (int i = 1; i <= 6; i++) press(7, "pc_new7", 2, therm(i));
    press(11, "pc_new_open", 4, 0);

    // Clear and edge cases
    press(1, "open_ignore_1", 4, 0);
    press(10, "open_star2", 1, 0);
    press(1, "clr_1", 1, therm(1));
    press(2, "clr_2", 1, therm(2));
    press(10, "clr_star", 1, 0);
    press_pins(4'b0001, 3'b100, 100, "hold_3", 1, therm(1));
    press_pins(4'b0001, 3'b011, 12, "multi_col", 1, therm(1));
    press_pins(4'b0011, 3'b001, 12, "multi_row", 1, therm(1));
    press(10, "clr_star2", 1, 0);
    pulse_reset("reset_in_on", 1, 0);
    press(11, "empty_hash", 2, 0);
    press(1, "w1_1", 2, therm(1));
    press(2, "w1_2", 2, therm(2));

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2;
    initialize = 1'b0;
    #1;
    check("async/state", 32'(state), 0);
    check("async/led", 32'(password_led), 0);
    @(negedge clk);
    initialize = 1'b1;
    repeat (2) @(negedge clk);
    press(5, "post_wake", 1, 0);
    for (int i = 1; i <= 4; i++) press(i, "post_1234", 1, therm(i));
    press(11, "post_open", 4, 0);

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
